// File: rtl/fp32_pkg.sv
// Shared FP32 / INT32 definitions for the FP32-to-INT32 converter.
// Contents: FP32 field layout, bias and limits, converter FSM state
// encoding and the out_flags bit positions.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          FP32_BIAS    = 127;
    localparam logic [7:0]  FP32_EXP_MAX = 8'd255;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ROUND = 3'd2,
        ST_SIGN  = 3'd3,
        ST_DONE  = 3'd4
    } conv_state_e;

    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

endpackage

// File: rtl/fp32_int_grs_round.sv
// Combinational rounding stage of the FP32-to-INT32 converter.
// Config macro: FP2INT_RNE_EN -- defined: round-to-nearest-even;
//                                undefined: round toward zero (no increment).
// Ports:
//   i_mag      unsigned integer magnitude before rounding
//   i_g/i_r/i_s guard, round, sticky bits below the integer lsb
//   o_mag      rounded magnitude (one extra bit so a carry-out is visible)
//   o_inexact  any discarded fraction bit was set
module fp32_int_grs_round (
    input  logic [31:0] i_mag,
    input  logic        i_g,
    input  logic        i_r,
    input  logic        i_s,
    output logic [32:0] o_mag,
    output logic        o_inexact
);

    logic w_inc;

`ifdef FP2INT_RNE_EN
    // Round up above half, or exactly half when the lsb is odd.
    assign w_inc = i_g & (i_r | i_s | i_mag[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign o_mag     = {1'b0, i_mag} + {32'd0, w_inc};
    assign o_inexact = i_g | i_r | i_s;

endmodule

// File: rtl/fp32_to_int32_conv.sv
// Multi-cycle FP32 -> signed INT32 converter with valid/ready on both sides.
// Config macro: FP2INT_RNE_EN (selects rounding mode in fp32_int_grs_round).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_data             FP32 operand {sign, exp, man}
//   out_valid/out_ready result handshake; result held until taken
//   out_data            signed integer result
//   out_flags           [2] invalid, [1] overflow, [0] inexact
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// ALIGN | classify operand, de-normalize, capture G/R/S
// ROUND | apply rounding, recheck overflow
// SIGN  | apply sign / saturation, register result and flags
// DONE  | out_valid=1 until out_ready
module fp32_to_int32_conv
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    conv_state_e r_state;
    conv_state_e w_next;

    fp32_t       r_op;
    logic [31:0] r_mag;
    logic        r_g;
    logic        r_r;
    logic        r_s;
    logic        r_inv;
    logic        r_ovf;
    logic        r_inx;
    logic [31:0] r_out_data;
    logic [2:0]  r_out_flags;

    // Align-stage combinational signals
    logic [23:0]       w_sig;
    logic signed [8:0] w_e;
    logic signed [8:0] w_rsh_full;
    logic [4:0]        w_rsh;
    logic [2:0]        w_lsh;
    logic [49:0]       w_ext;
    logic [31:0]       w_a_mag;
    logic              w_a_g;
    logic              w_a_r;
    logic              w_a_s;
    logic              w_a_inv;
    logic              w_a_ovf;
    logic              w_a_inx;

    // Round-stage signals
    logic [32:0] w_rnd_mag;
    logic        w_rnd_inx;
    logic        w_rnd_ovf;

    // Sign-stage signals
    logic [31:0] w_res;
    logic [2:0]  w_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_ALIGN;
            ST_ALIGN: w_next = ST_ROUND;
            ST_ROUND: w_next = ST_SIGN;
            ST_SIGN:  w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;

    always_comb begin
        w_sig      = {1'b1, r_op.man};
        w_e        = $signed({1'b0, r_op.exp}) - 9'(FP32_BIAS);
        w_lsh      = 3'(w_e - 9'sd23);
        w_rsh_full = 9'sd23 - w_e;
        // Beyond 26 the whole significand already sits below the sticky bit.
        w_rsh      = (w_rsh_full > 9'sd26) ? 5'd26 : w_rsh_full[4:0];
        // Significand with 26 fraction bits: [49:26] integer, [25] G, [24] R.
        w_ext      = {w_sig, 26'd0} >> w_rsh;

        w_a_mag = 32'd0;
        w_a_g   = 1'b0;
        w_a_r   = 1'b0;
        w_a_s   = 1'b0;
        w_a_inv = 1'b0;
        w_a_ovf = 1'b0;
        w_a_inx = 1'b0;

        if (r_op.exp == FP32_EXP_MAX) begin
            if (r_op.man != 23'd0) w_a_inv = 1'b1;
            else                   w_a_ovf = 1'b1;
        end else if (r_op.exp == 8'd0) begin
            // Zero/denormal: result is zero, never rounded up.
            w_a_inx = (r_op.man != 23'd0);
        end else if (w_e >= 9'sd31) begin
            // -2^31 is the only representable value with E=31.
            if (r_op.sign && (w_e == 9'sd31) && (r_op.man == 23'd0)) begin
                w_a_mag = INT32_MIN;
            end else begin
                w_a_ovf = 1'b1;
            end
        end else if (w_e >= 9'sd23) begin
            w_a_mag = {8'd0, w_sig} << w_lsh;
        end else begin
            w_a_mag = {8'd0, w_ext[49:26]};
            w_a_g   = w_ext[25];
            w_a_r   = w_ext[24];
            w_a_s   = |w_ext[23:0];
        end
    end

    fp32_int_grs_round u_round (
        .i_mag     (r_mag),
        .i_g       (r_g),
        .i_r       (r_r),
        .i_s       (r_s),
        .o_mag     (w_rnd_mag),
        .o_inexact (w_rnd_inx)
    );

    assign w_rnd_ovf = r_op.sign ? (w_rnd_mag > {1'b0, INT32_MIN})
                                 : (w_rnd_mag > {1'b0, INT32_MAX});

    always_comb begin
        w_res   = r_mag;
        w_flags = 3'b000;
        if (r_inv) begin
            w_res                 = INT32_MAX;
            w_flags[FLAG_INVALID] = 1'b1;
        end else if (r_ovf) begin
            w_res                  = r_op.sign ? INT32_MIN : INT32_MAX;
            w_flags[FLAG_OVERFLOW] = 1'b1;
        end else begin
            w_res                 = r_op.sign ? (~r_mag + 32'd1) : r_mag;
            w_flags[FLAG_INEXACT] = r_inx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_mag       <= 32'd0;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= 1'b0;
            r_inv       <= 1'b0;
            r_ovf       <= 1'b0;
            r_inx       <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_flags <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) r_op <= fp32_t'(in_data);
                end
                ST_ALIGN: begin
                    r_mag <= w_a_mag;
                    r_g   <= w_a_g;
                    r_r   <= w_a_r;
                    r_s   <= w_a_s;
                    r_inv <= w_a_inv;
                    r_ovf <= w_a_ovf;
                    r_inx <= w_a_inx;
                end
                ST_ROUND: begin
                    r_mag <= w_rnd_mag[31:0];
                    r_inx <= r_inx | w_rnd_inx;
                    r_ovf <= r_ovf | w_rnd_ovf;
                end
                ST_SIGN: begin
                    r_out_data  <= w_res;
                    r_out_flags <= w_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
module tb_fp32_to_int32_conv;

`ifdef FP2INT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    fp32_to_int32_conv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic [2:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  f;
    } exp_t;

    localparam int NV = 21;
    vec_t vecs[NV];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx);
        int n = 0;
        in_data  = vecs[idx].din;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout[%0d]: in_ready got 0 expected 1", idx);
            in_valid = 1'b0;
            return;
        end
        sb.push_back({vecs[idx].dout, vecs[idx].flags});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input int idx);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty[%0d]: got output with no expected entry", idx);
            return;
        end
        e = sb.pop_front();
        check($sformatf("data[%0d]", idx), out_data, e.d);
        check($sformatf("flags[%0d]", idx), {29'd0, out_flags}, {29'd0, e.f});
    endtask

    task automatic recv(input int idx);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL recv_timeout[%0d]: out_valid got 0 expected 1", idx);
            return;
        end
        pop_check(idx);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int   acc[$];
        int   ov[$];
        int   nacc;
        int   lat;
        logic [31:0] hold_d;
        logic [2:0]  hold_f;

        vecs[0]  = '{32'h3FC0_0000, RNE ? 32'h0000_0002 : 32'h0000_0001, 3'b001}; // 1.5
        vecs[1]  = '{32'h4020_0000, 32'h0000_0002, 3'b001};                       // 2.5
        vecs[2]  = '{32'hC060_0000, RNE ? 32'hFFFF_FFFC : 32'hFFFF_FFFD, 3'b001}; // -3.5
        vecs[3]  = '{32'h3F00_0000, 32'h0000_0000, 3'b001};                       // 0.5
        vecs[4]  = '{32'h0000_0001, 32'h0000_0000, 3'b001};                       // denormal
        vecs[5]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010};                       // 2^31
        vecs[6]  = '{32'hCF00_0000, 32'h8000_0000, 3'b000};                       // -2^31
        vecs[7]  = '{32'hFF80_0000, 32'h8000_0000, 3'b010};                       // -Inf
        vecs[8]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100};                       // NaN
        vecs[9]  = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 3'b000};
        vecs[10] = '{32'h3F40_0000, RNE ? 32'h0000_0001 : 32'h0000_0000, 3'b001}; // 0.75
        vecs[11] = '{32'h3FA0_0000, 32'h0000_0001, 3'b001};                       // 1.25
        vecs[12] = '{32'h3FE0_0000, RNE ? 32'h0000_0002 : 32'h0000_0001, 3'b001}; // 1.75
        vecs[13] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000};                       // E=30 max
        vecs[14] = '{32'hCEFF_FFFF, 32'h8000_0080, 3'b000};
        vecs[15] = '{32'h0000_0000, 32'h0000_0000, 3'b000};                       // +0
        vecs[16] = '{32'h8000_0000, 32'h0000_0000, 3'b000};                       // -0
        vecs[17] = '{32'h7F80_0000, 32'h7FFF_FFFF, 3'b010};                       // +Inf
        vecs[18] = '{32'hFFC0_0001, 32'h7FFF_FFFF, 3'b100};                       // -NaN
        vecs[19] = '{32'hCF00_0001, 32'h8000_0000, 3'b010};                       // just below -2^31
        vecs[20] = '{32'h0D80_0000, 32'h0000_0000, 3'b001};                       // 2^-100

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", {29'd0, out_flags}, 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Table vectors, one at a time
        for (int i = 0; i < NV; i++) begin
            send(i);
            recv(i);
        end

        // Latency: out_valid first seen 4 cycles after the accept cycle
        in_data  = vecs[9].din;
        in_valid = 1'b1;
        check("lat_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back({vecs[9].dout, vecs[9].flags});
        lat = 0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 32'd4);
        recv(100);

        // Back-to-back with in_valid and out_ready held high
        nacc      = 0;
        in_valid  = 1'b1;
        in_data   = vecs[0].din;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            logic took;
            took = 1'b0;
            if (out_valid) begin
                ov.push_back(c);
                pop_check(200 + c);
            end
            if (in_valid && in_ready) begin
                acc.push_back(c);
                sb.push_back({vecs[nacc].dout, vecs[nacc].flags});
                nacc++;
                took = 1'b1;
            end
            tick();
            if (took) begin
                if (nacc < 3) in_data = vecs[nacc].din;
                else          in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_accepts", acc.size(), 32'd3);
        check("b2b_outputs", ov.size(), 32'd3);
        if (acc.size() == 3 && ov.size() == 3) begin
            check("b2b_gap1", acc[1] - acc[0], 32'd5);
            check("b2b_gap2", acc[2] - acc[1], 32'd5);
            for (int k = 0; k < 3; k++)
                check($sformatf("b2b_lat%0d", k), ov[k] - acc[k], 32'd4);
        end
        check("b2b_sb_empty", sb.size(), 32'd0);
        sb.delete();

        // Output stall: result held, no new accept
        send(2);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        hold_d = vecs[2].dout;
        hold_f = vecs[2].flags;
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_data", out_data, hold_d);
            check("stall_flags", {29'd0, out_flags}, {29'd0, hold_f});
            tick();
        end
        recv(300);

        // Reset during ROUND
        in_data  = vecs[5].din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_data", out_data, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("abort_idle_valid", {31'd0, out_valid}, 32'd0);
        send(12);
        recv(400);
        send(7);
        recv(401);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
